// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned keypad front end with per-key debounce and
// an event FIFO that hands key codes to the CPU over a valid/ready handshake.
//
// Optional feature: define KEY_RELEASE_EN to also queue release events
// (code bit [KEY_W] = 1). Without it, releases update the debounced state
// silently and code bit [KEY_W] is always 0.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_h          column sense, 0 = key closed on the driven row
//   o_v          row drive, one-hot active-low (all 1s in reset)
//   o_key_valid  FIFO non-empty
//   o_key_code   head entry: [KEY_W-1:0] = row*COLS+col, [KEY_W] = release
//   i_key_ready  consumer takes the head entry (pop on valid & ready)
//   o_overflow   sticky: an event was dropped because the FIFO was full
//   i_clr_ovf    clears o_overflow
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int KEY_W      = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [COLS-1:0]  i_h,
  output logic [ROWS-1:0]  o_v,
  output logic             o_key_valid,
  output logic [KEY_W:0]   o_key_code,
  input  logic             i_key_ready,
  output logic             o_overflow,
  input  logic             i_clr_ovf
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int CW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;

  // ---------------- scan ----------------
  logic [DW-1:0]   r_div;
  logic [RW-1:0]   r_row;
  logic [ROWS-1:0] r_v;
  logic            w_sample;

  assign w_sample = (r_div == DW'(SCAN_DIV - 1));
  assign o_v      = r_v;

  // The row drive lags the row index by one cycle, so a row is driven for
  // SCAN_DIV-1 cycles before its sampling edge and columns have settled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_row <= '0;
      r_v   <= '1;
    end else begin
      r_v <= ~(ROWS'(1) << r_row);
      if (w_sample) begin
        r_div <= '0;
        r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  // ---------------- debounce ----------------
  logic [CW-1:0]    r_cnt [ROWS][COLS];
  logic             r_stb [ROWS][COLS];
  logic [COLS-1:0]  w_raw, w_diff, w_qual, w_evt, w_win;
  logic             w_any;
  logic [CLW-1:0]   w_col;
  logic [KEY_W-1:0] w_code;

  always_comb begin
    w_raw  = ~i_h;
    w_diff = '0;
    w_qual = '0;
    w_evt  = '0;
    w_win  = '0;
    w_any  = 1'b0;
    w_col  = '0;
    for (int c = 0; c < COLS; c++) begin
      w_diff[c] = (w_raw[c] != r_stb[r_row][c]);
      w_qual[c] = w_diff[c] && (r_cnt[r_row][c] == CW'(DEBOUNCE - 1));
`ifdef KEY_RELEASE_EN
      w_evt[c]  = w_qual[c];
`else
      w_evt[c]  = w_qual[c] & w_raw[c];  // releases never compete for the slot
`endif
    end
    // only the lowest event-generating column commits in a given sample
    for (int c = 0; c < COLS; c++) begin
      if (w_evt[c] && !w_any) begin
        w_win[c] = 1'b1;
        w_any    = 1'b1;
        w_col    = CLW'(c);
      end
    end
    w_code = KEY_W'(int'(r_row) * COLS + int'(w_col));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          r_cnt[r][c] <= '0;
          r_stb[r][c] <= 1'b0;
        end
    end else if (w_sample) begin
      for (int c = 0; c < COLS; c++) begin
        if (!w_diff[c]) begin
          r_cnt[r_row][c] <= '0;
        end else if (w_qual[c]) begin
          // losers of the arbitration keep count DEBOUNCE-1 and retry next frame
          if (w_win[c] || !w_evt[c]) begin
            r_stb[r_row][c] <= w_raw[c];
            r_cnt[r_row][c] <= '0;
          end
        end else begin
          r_cnt[r_row][c] <= r_cnt[r_row][c] + CW'(1);
        end
      end
    end
  end

  // registered push stage between the sampler and the FIFO
  logic           r_push;
  logic [KEY_W:0] r_push_code;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_push      <= 1'b0;
      r_push_code <= '0;
    end else begin
      r_push <= w_sample && w_any;
      if (w_sample && w_any) begin
`ifdef KEY_RELEASE_EN
        r_push_code <= {~w_raw[w_col], w_code};
`else
        r_push_code <= {1'b0, w_code};
`endif
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [KEY_W:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wp, r_rp;
  logic [NW-1:0]  r_count;
  logic [KEY_W:0] r_last;
  logic           r_ovf;
  logic           w_pop, w_full, w_wr, w_drop;

  assign o_key_valid = (r_count != '0);
  // show-ahead head; when empty, keep presenting the last head that was shown
  assign o_key_code  = o_key_valid ? r_mem[r_rp] : r_last;
  assign o_overflow  = r_ovf;

  assign w_pop  = o_key_valid & i_key_ready;
  assign w_full = (r_count == NW'(FIFO_DEPTH));
  assign w_wr   = r_push && (!w_full || w_pop);
  assign w_drop = r_push && w_full && !w_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_last  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= r_push_code;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_last <= r_mem[r_rp];
        r_rp   <= r_rp + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
      // a drop in the same cycle as a clear leaves the flag set
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
    end
  end

endmodule
